// File: rtl/fir.sv
// 16-tap direct-form FIR filter with serially loaded weights and samples.
// Weights and samples shift in over the shared data bus.
// An 8-stage multiply / adder-tree / saturate pipeline produces one result per cycle.
module fir (
   input  logic        clk,
   input  logic        rst,
   input  logic        wind,
   input  logic        load,
   input  logic        in_valid,
   input  logic [15:0] data,
   output logic        out_valid,
   output logic [15:0] out
);

   localparam int TAPS = 16;

   // Register chains and the value each element takes when its chain shifts
   logic signed [15:0] w_reg [TAPS];
   logic signed [15:0] d_reg [TAPS];
   logic signed [15:0] w_next [TAPS];
   logic signed [15:0] d_next [TAPS];

   // Pipeline data: products, adder tree levels, saturated value, output stages
   logic signed [31:0] prod_reg [TAPS];
   logic signed [35:0] sum1_reg [8];
   logic signed [35:0] sum2_reg [4];
   logic signed [35:0] sum3_reg [2];
   logic signed [35:0] sum4_reg;
   logic signed [15:0] sat_next;
   logic signed [15:0] sat_reg;
   logic signed [15:0] stage7_reg;
   logic signed [15:0] out_reg;

   // Valid bit for each of the 8 register stages; vld_reg[8] drives out_valid
   logic [8:1] vld_reg;

   genvar gi;

   // Element 0 takes the bus word; every other element takes its predecessor
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_shift_src
         if (gi == 0) begin : g_head
            assign w_next[gi] = data;
            assign d_next[gi] = data;
         end else begin : g_body
            assign w_next[gi] = w_reg[gi-1];
            assign d_next[gi] = d_reg[gi-1];
         end
      end
   endgenerate

   // Weight and sample chains shift independently under wind / load
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_chain
         // Shift one tap of each chain when its enable is high, otherwise hold
         always_ff @(posedge clk) begin
            if (rst) begin
               w_reg[gi] <= '0;
               d_reg[gi] <= '0;
            end else begin
               if (wind) w_reg[gi] <= w_next[gi];
               if (load) d_reg[gi] <= d_next[gi];
            end
         end
      end
   endgenerate

   // Stage 1: snapshot the chains into full-precision products
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_prod
         // Register one tap product from the pre-shift chain contents
         always_ff @(posedge clk) begin
            if (rst) prod_reg[gi] <= '0;
            else     prod_reg[gi] <= w_reg[gi] * d_reg[gi];
         end
      end
   endgenerate

   // Stage 2: first adder level, products sign-extended to the 36-bit accumulator
   generate
      for (gi = 0; gi < 8; gi++) begin : g_sum1
         // Pairwise sum of adjacent products
         always_ff @(posedge clk) begin
            if (rst) sum1_reg[gi] <= '0;
            else     sum1_reg[gi] <= {{4{prod_reg[2*gi][31]}}, prod_reg[2*gi]}
                                   + {{4{prod_reg[2*gi+1][31]}}, prod_reg[2*gi+1]};
         end
      end
   endgenerate

   // Stage 3: 8 -> 4
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sum2
         // Pairwise sum of first-level partials
         always_ff @(posedge clk) begin
            if (rst) sum2_reg[gi] <= '0;
            else     sum2_reg[gi] <= sum1_reg[2*gi] + sum1_reg[2*gi+1];
         end
      end
   endgenerate

   // Stage 4: 4 -> 2
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sum3
         // Pairwise sum of second-level partials
         always_ff @(posedge clk) begin
            if (rst) sum3_reg[gi] <= '0;
            else     sum3_reg[gi] <= sum2_reg[2*gi] + sum2_reg[2*gi+1];
         end
      end
   endgenerate

   // Stage 5: final sum
   always_ff @(posedge clk) begin
      if (rst) sum4_reg <= '0;
      else     sum4_reg <= sum3_reg[0] + sum3_reg[1];
   end

   // Clamp the 36-bit sum into the signed 16-bit range
   always_comb begin
      sat_next = sum4_reg[15:0];
      if (sum4_reg > 36'sd32767)
         sat_next = 16'sh7FFF;
      else if (sum4_reg < -36'sd32768)
         sat_next = 16'sh8000;
   end

   // Stage 6: register the saturated value
   always_ff @(posedge clk) begin
      if (rst) sat_reg <= '0;
      else     sat_reg <= sat_next;
   end

   // Stages 7-8: output registers only load valid results so out holds between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         stage7_reg <= '0;
         out_reg    <= '0;
      end else begin
         if (vld_reg[6]) stage7_reg <= sat_reg;
         if (vld_reg[7]) out_reg    <= stage7_reg;
      end
   end

   // Valid bit travels alongside the data through all 8 stages
   always_ff @(posedge clk) begin
      if (rst) vld_reg <= '0;
      else     vld_reg <= {vld_reg[7:1], in_valid};
   end

   assign out_valid = vld_reg[8];
   assign out       = out_reg;

endmodule

// File: tb/tb_fir.sv
// Randomized and directed bench for the 16-tap FIR filter.
// A behavioural model computes each launched dot product and schedules it 7 edges later.
module tb_fir;

   logic        clk;
   logic        rst;
   logic        wind;
   logic        load;
   logic        in_valid;
   logic [15:0] data;
   logic        out_valid;
   logic [15:0] out;

   int errors = 0;
   int checks = 0;

   fir dut (
      .clk       (clk),
      .rst       (rst),
      .wind      (wind),
      .load      (load),
      .in_valid  (in_valid),
      .data      (data),
      .out_valid (out_valid),
      .out       (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct {
      int          due;
      logic [15:0] val;
   } result_t;

   logic signed [15:0] mw [16];
   logic signed [15:0] md [16];
   result_t            q [$];
   int                 cyc     = 0;
   int                 rst_cyc = -1;
   bit                 started = 0;

   function automatic logic [15:0] clamp16(input longint s);
      if (s > 32767)       return 16'h7FFF;
      else if (s < -32768) return 16'h8000;
      else                 return 16'(s);
   endfunction

   // Model update: result uses the chains as they were before this edge's shifts
   always @(posedge clk) begin
      longint  acc;
      result_t r;
      cyc++;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            mw[i] = '0;
            md[i] = '0;
         end
         q.delete();
         rst_cyc = cyc;
         started = 1;
      end else begin
         if (in_valid) begin
            acc = 0;
            for (int i = 0; i < 16; i++)
               acc += longint'(md[i]) * longint'(mw[i]);
            r.due = cyc + 7;
            r.val = clamp16(acc);
            q.push_back(r);
         end
         if (wind) begin
            for (int i = 15; i > 0; i--) mw[i] = mw[i-1];
            mw[0] = data;
         end
         if (load) begin
            for (int i = 15; i > 0; i--) md[i] = md[i-1];
            md[0] = data;
         end
      end
   end

   // Compare process: every cycle after the first reset
   logic [15:0] exp_out_hold = '0;
   always @(negedge clk) begin
      logic exp_v;
      if (started) begin
         exp_v = 1'b0;
         if (rst_cyc == cyc) exp_out_hold = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_v        = 1'b1;
            exp_out_hold = q[0].val;
            void'(q.pop_front());
         end
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
         end
         checks++;
         if (out !== exp_out_hold) begin
            errors++;
            $display("FAIL out cyc=%0d got=%h exp=%h", cyc, out, exp_out_hold);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check_val(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, expv);
      end else
         $display("check %s = %0d ok", name, act);
   endtask

   task automatic drive(input logic wi, input logic lo, input logic iv, input logic [15:0] dat);
      @(negedge clk);
      rst = 1'b0; wind = wi; load = lo; in_valid = iv; data = dat;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; wind = 1'b0; load = 1'b0; in_valid = 1'b0; data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Push 16 words into the weight chain (mode 0) or sample chain (mode 1)
   task automatic push16(input bit to_samples, input logic [15:0] v [16]);
      for (int j = 0; j < 16; j++)
         drive(!to_samples, to_samples, 1'b0, v[j]);
   endtask

   // Launch with in_valid high for nvalid cycles, then watch n cycles.
   // Optional sample reload (zeros) for load_cycles and a reset pulse at rst_at.
   task automatic run_capture(input int nvalid, input int load_cycles, input int rst_at,
                              output int cnt, output int first_lat,
                              output int first_val, output int last_val);
      cnt = 0; first_lat = -1; first_val = -99999; last_val = -99999;
      drive(1'b0, 1'b0, 1'b1, 16'h0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         rst      = (i == rst_at);
         wind     = 1'b0;
         load     = (i <= load_cycles);
         in_valid = (i < nvalid);
         data     = '0;
         if (out_valid === 1'b1) begin
            cnt++;
            if (first_lat < 0) begin
               first_lat = i;
               first_val = int'($signed(out));
            end
            last_val = int'($signed(out));
         end
      end
      if (cnt == 0) begin
         first_val = int'($signed(out));
         last_val  = int'($signed(out));
      end
   endtask

   logic [15:0] ones [16];
   logic [15:0] ramp [16];
   logic [15:0] negs [16];
   logic [15:0] maxp [16];
   logic [15:0] minn [16];
   logic [15:0] zers [16];

   initial begin
      int cnt, lat, fv, lv;
      rst = 1'b1; wind = 1'b0; load = 1'b0; in_valid = 1'b0; data = '0;
      for (int j = 0; j < 16; j++) begin
         ones[j] = 16'd1;
         ramp[j] = 16'(j + 1);
         negs[j] = 16'hFFFF;
         maxp[j] = 16'h7FFF;
         minn[j] = 16'h8000;
         zers[j] = 16'h0000;
      end
      reset_dut();
      @(negedge clk);
      check_val("reset_out", int'(out), 0);
      check_val("reset_out_valid", int'(out_valid), 0);

      // 1. basic sum
      push16(0, ones); push16(1, ramp);
      run_capture(6, 0, 0, cnt, lat, fv, lv);
      check_val("basic_count", cnt, 6);
      check_val("basic_latency", lat, 8);
      check_val("basic_first", fv, 136);
      check_val("basic_last", lv, 136);

      // 2. ordering
      reset_dut();
      push16(0, ramp); push16(1, ramp);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("order_count", cnt, 1);
      check_val("order_value", fv, 1496);

      // 3. negative weights
      push16(0, negs);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("neg_value", fv, -136);

      // 4. saturation both ways
      push16(0, maxp); push16(1, maxp);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("sat_pos", fv, 32767);
      push16(1, minn);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("sat_neg", fv, -32768);

      // 5. in-flight isolation: reload zeros while the result travels
      push16(0, ones); push16(1, ramp);
      run_capture(1, 16, 0, cnt, lat, fv, lv);
      check_val("inflight_value", fv, 136);
      check_val("inflight_count", cnt, 1);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("after_reload", fv, 0);

      // 6. mid-operation reset
      push16(1, ramp);
      run_capture(1, 0, 3, cnt, lat, fv, lv);
      check_val("midrst_count", cnt, 0);
      check_val("midrst_out", int'(out), 0);
      run_capture(1, 0, 0, cnt, lat, fv, lv);
      check_val("post_rst_value", fv, 0);

      // Randomized traffic, checked every cycle by the compare process
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 299) == 0);
         wind     = ($urandom_range(0, 2) == 0);
         load     = ($urandom_range(0, 2) == 0);
         in_valid = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       data = 16'($urandom);
            1:       data = 16'($signed($urandom_range(0, 100)) - 50);
            2:       data = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            default: data = 16'($urandom_range(0, 255));
         endcase
      end
      @(negedge clk);
      rst = 1'b0; wind = 1'b0; load = 1'b0; in_valid = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
